if_stage_fetch: RTL
===================

Name: if_stage_fetch

Overview:
- Fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns PC; handles instruction-memory handshake with variable latency.
- Holds IF/ID and PC while the hazard unit's Stall is high, or inserts bubbles.
- Applies branch/jump redirects after the delay slot; flushes on exception/eret redirect.
- Produces InstrD/PCD, which feed decode and the stall unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset release.
- EXC_PC, 32'h0000_4180, exception handler entry.
- NOP_INSTR, 32'h0000_0000, instruction inserted as bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  from hazard unit; freeze PC and IF/ID.
- BrTakeD  in  1  branch/jump in D taken; qualified by !Stall.
- BrTargetD  in  32  redirect target for BrTakeD.
- ExcFlush  in  1  exception/eret redirect; overrides everything, including Stall.
- ExcTarget  in  32  EXC_PC or EPC, selected upstream.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata valid this cycle; completes request.
- imem_rdata  in  32  fetched word.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PC8D  out  32  PCD+8 (link value for jal/jalr/bgezal).
- ValidD  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset=0):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=RESET_PC, ValidD=0, state=FETCH.
  - Pending-redirect flag and buffer cleared; imem_req=0 while in reset.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PCF.
    - Word is "ready" when imem_ready=1.
    - Ready and !Stall: load IF/ID, advance PC.
    - Ready and Stall: capture word into buffer, go to BUF.
  - BUF: imem_req=0; word buffered.
    - On !Stall: load IF/ID from buffer, advance PC, go to FETCH.
  - DROP: request outstanding but squashed; imem_req=1, imem_addr held at old PCF.
    - On imem_ready: discard word, PCF←latched redirect, go to FETCH.
- IF/ID update, each cycle:
  - ExcFlush: InstrD=NOP_INSTR, ValidD=0.
  - Else Stall: hold all IF/ID outputs.
  - Else word available (ready in FETCH, or BUF): load InstrD/PCD, ValidD=1.
  - Else: bubble (NOP_INSTR, ValidD=0, PCD unchanged).
- PC advance:
  - Next PC = pending redirect target if pending, else PCF+4 (32-bit wrap, no carry).
  - Pending is cleared when consumed.
- Branch (BrTakeD & !Stall):
  - The current F instruction is the delay slot and is never squashed.
  - Delay slot completes in this same cycle (ready in FETCH, or BUF draining): next PC = BrTargetD directly.
  - Otherwise: latch target as pending; applied when the delay slot is delivered.
  - BrTakeD with Stall=1 is ignored; the stall unit holds the branch in D.
- ExcFlush: highest priority, acts even when Stall=1.
  - IF/ID bubbled; pending redirect cleared; buffer discarded.
  - In FETCH with imem_ready=0: go to DROP, latch ExcTarget.
  - In FETCH with ready, or in BUF: PCF←ExcTarget, go to FETCH next cycle.
  - ExcFlush in DROP: overwrite latched target.
- Simultaneous ExcFlush and BrTakeD: exception wins; branch discarded.
- Reset mid-request: outstanding request abandoned; memory must tolerate req dropping.
- PC8D = PCD+8, combinational from PCD.
- Latency: minimum one instruction per cycle with single-cycle imem_ready; branch penalty zero beyond the delay slot.

Optional Feature:
- Macro FETCH_ADEL_EN.
- Defined:
  - PCF[1:0]≠0 in FETCH: no request issued; IF/ID loads NOP_INSTR with ValidD=1.
  - Extra output AdelD=1 (1 bit) travels with that instruction; PC then stalls until ExcFlush.
  - AdelD resets to 0 and clears on any IF/ID load.
- Undefined: port absent; PCF[1:0] ignored; imem_addr={PCF[31:2],2'b00}.

Test Plan:
- Reset release, imem_ready=1 constant → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; ValidD=1 from the second cycle; PC8D=PCD+8.
- Stall=1 for 3 cycles while fetching 0x3008 → InstrD/PCD frozen at 0x3004; FSM to BUF; word of 0x3008 enters D the cycle after Stall falls; no re-fetch.
- imem_ready delayed 2 cycles each fetch → imem_addr stable during wait; bubbles (ValidD=0) inserted; order preserved.
- BrTakeD at PCD=0x3004, target 0x3100, delay slot still waiting → 0x3008 delivered, next request 0x3100.
- ExcFlush with ExcTarget=0x4180 while request to 0x300C is outstanding (ready arrives 2 cycles later) → DROP; returned word discarded; ValidD=0; next request 0x4180.
- FETCH_ADEL_EN, BrTargetD=0x3102 → no imem_req at 0x3102; AdelD=1 with ValidD=1; PC held until ExcFlush.

Source files
------------

// File: rtl/if_stage_fetch.sv
// ---------------------------------------------------------------------------
// if_stage_fetch
//
// Instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS
// pipeline. Owns the fetch PC, runs the instruction-memory handshake
// (variable latency), and fills the IF/ID register that feeds decode.
//
// Instruction-memory handshake:
//   imem_req is a request that, once raised, stays high with imem_addr
//   stable until the cycle imem_ready=1. That cycle completes the request
//   and imem_rdata is valid in it. imem_ready outside a request is ignored.
//   When reset is asserted the request is dropped at once.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   Stall       hazard-unit stall: freeze PC and IF/ID
//   BrTakeD     taken branch/jump in D (only honoured with Stall=0)
//   BrTargetD   branch/jump target
//   ExcFlush    exception/eret redirect, beats everything including Stall
//   ExcTarget   exception/eret target (EXC_PC or EPC, selected upstream)
//   imem_req    fetch request
//   imem_addr   word-aligned fetch address
//   imem_ready  fetch completes this cycle
//   imem_rdata  fetched word
//   PCF         current fetch PC
//   InstrD      IF/ID instruction
//   PCD         IF/ID PC
//   PC8D        PCD+8 (link value)
//   ValidD      IF/ID holds a real instruction
//   AdelD       address-error-on-fetch flag (only with FETCH_ADEL_EN)
//   dbg_state   FSM state (0 FETCH, 1 BUF, 2 DROP, 3 HALT)
//
// Build option:
//   FETCH_ADEL_EN  when defined, a misaligned PCF issues no fetch; a NOP is
//                  delivered to D with ValidD=1 and AdelD=1, and fetch halts
//                  until ExcFlush. When undefined, PCF[1:0] is ignored.
// ---------------------------------------------------------------------------
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BrTakeD,
  input  logic [31:0] BrTargetD,
  input  logic        ExcFlush,
  input  logic [31:0] ExcTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC8D,
  output logic        ValidD,
`ifdef FETCH_ADEL_EN
  output logic        AdelD,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at PCF
    S_BUF   = 2'd1,  // word returned during a stall, parked in buf_q
    S_DROP  = 2'd2,  // squashed request still in flight, wait it out
    S_HALT  = 2'd3   // fetch halted after an address error
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] buf_q,      buf_d;
  logic        pend_q,     pend_d;      // redirect waiting for delay slot
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] exc_tgt_q,  exc_tgt_d;   // target applied when DROP ends
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pcd_q,      pcd_d;
  logic        valid_q,    valid_d;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  logic        misaligned;
  logic        br_ok;
  logic [31:0] seq_pc;
  logic [31:0] adv_pc;

`ifdef FETCH_ADEL_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A branch is only acted on when D can move and no exception is
  // redirecting this cycle; with Stall the hazard unit keeps it in D.
  assign br_ok  = BrTakeD & ~Stall & ~ExcFlush;

  // Normal successor: a pending redirect (delay slot now delivered) or PC+4.
  assign seq_pc = pend_q ? pend_tgt_q : (pc_q + 32'd4);

  // PC to use when the current F word (the delay slot if a branch is in D)
  // leaves F this cycle. A branch arriving in the same cycle redirects
  // directly, so there is no penalty beyond the delay slot.
  assign adv_pc = br_ok ? BrTargetD : seq_pc;

  // -------------------------------------------------------------------------
  // Next-state / IF/ID logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    exc_tgt_d  = exc_tgt_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    valid_d    = valid_q;

    if (ExcFlush) begin
      // Bubble D, forget any pending branch redirect and any buffered word.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (!misaligned && !imem_ready) begin
            // Request cannot be withdrawn; let it land in DROP.
            state_d   = S_DROP;
            exc_tgt_d = ExcTarget;
          end else begin
            pc_d    = ExcTarget;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            pc_d    = ExcTarget;
            state_d = S_FETCH;
          end else begin
            exc_tgt_d = ExcTarget;
          end
        end
        default: begin
          pc_d    = ExcTarget;
          state_d = S_FETCH;
        end
      endcase
    end else begin
      // Without a stall, D is a bubble unless a word is loaded below.
      if (!Stall) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end

      unique case (state_q)
        S_FETCH: begin
          if (misaligned) begin
            // Address error: no request; NOP carries the error to D.
            if (!Stall) begin
              valid_d = 1'b1;
              pcd_d   = pc_q;
              state_d = S_HALT;
            end
          end else if (imem_ready) begin
            if (!Stall) begin
              instr_d = imem_rdata;
              pcd_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = adv_pc;
              pend_d  = 1'b0;
            end else begin
              buf_d   = imem_rdata;
              state_d = S_BUF;
            end
          end else if (br_ok) begin
            // Delay slot still in flight: apply target once it is delivered.
            pend_d     = 1'b1;
            pend_tgt_d = BrTargetD;
          end
        end
        S_BUF: begin
          if (!Stall) begin
            instr_d = buf_q;
            pcd_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = adv_pc;
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            pc_d    = exc_tgt_q;
            state_d = S_FETCH;
          end
        end
        default: begin
          // S_HALT: wait for ExcFlush.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      buf_q      <= NOP_INSTR;
      pend_q     <= 1'b0;
      pend_tgt_q <= RESET_PC;
      exc_tgt_q  <= EXC_PC;
      instr_q    <= NOP_INSTR;
      pcd_q      <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      exc_tgt_q  <= exc_tgt_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_ADEL_EN
  // AdelD rides only with the NOP that reports the error; any other IF/ID
  // load (including bubbles and flushes) clears it.
  logic adel_q, adel_d;

  always_comb begin
    adel_d = adel_q;
    if (ExcFlush) begin
      adel_d = 1'b0;
    end else if (!Stall) begin
      adel_d = (state_q == S_FETCH) && misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adel_q <= 1'b0;
    end else begin
      adel_q <= adel_d;
    end
  end

  assign AdelD = adel_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Gated by reset so the request drops immediately when reset asserts.
  assign imem_req  = reset & (((state_q == S_FETCH) & ~misaligned) |
                              (state_q == S_DROP));
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign PCF       = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PC8D      = pcd_q + 32'd8;
  assign ValidD    = valid_q;
  assign dbg_state = state_q;

endmodule
